// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter feeding one registered add/sub datapath shared by NUM_REQ requesters.
// Optional signed-overflow output enabled by defining ADDSUB_ARB_OVF_EN.
module addsub_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]         req_sub,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_data,
  output logic [IDW-1:0]             res_id,
`ifdef ADDSUB_ARB_OVF_EN
  output logic                       res_ovf,
`endif
  output logic [15:0]                ops_done
);

  localparam int unsigned CW = IDW + 1;

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   ptr_q;
  logic [15:0]      ops_q;

  logic             grant_valid;
  logic [IDW-1:0]   grant_idx;
  logic [CW-1:0]    cand;
  logic             accept;
  logic             fire;
  logic [IDW-1:0]   ptr_next;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             sub_sel;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] result;

  // Scan from ptr upward, wrapping; the first valid requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!grant_valid && req_valid[cand[IDW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  assign accept    = (state_q == StEmpty) | res_ready;
  assign fire      = grant_valid & accept & ~reset;
  assign req_ready = fire ? (NUM_REQ'(1) << grant_idx) : '0;
  assign ptr_next  = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);

  assign a_sel   = req_a[grant_idx*WIDTH +: WIDTH];
  assign b_sel   = req_b[grant_idx*WIDTH +: WIDTH];
  assign sub_sel = req_sub[grant_idx];

  // Subtraction as a + ~b + 1, with the +1 folded in as carry-in.
  assign b_op   = sub_sel ? ~b_sel : b_sel;
  assign result = a_sel + b_op + WIDTH'(sub_sel);

`ifdef ADDSUB_ARB_OVF_EN
  logic ovf_q;
  logic ovf_d;

  always_comb begin
    ovf_d = 1'b0;
    if (result[WIDTH-1] != a_sel[WIDTH-1]) begin
      ovf_d = sub_sel ? (a_sel[WIDTH-1] != b_sel[WIDTH-1])
                      : (a_sel[WIDTH-1] == b_sel[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (fire) begin
      ovf_q <= ovf_d;
    end
  end

  assign res_ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      ops_q   <= '0;
    end else begin
      if (fire) begin
        state_q <= StFull;
        data_q  <= result;
        id_q    <= grant_idx;
        ptr_q   <= ptr_next;
      end else if (res_ready) begin
        state_q <= StEmpty;
      end
      if ((state_q == StFull) && res_ready) begin
        ops_q <= ops_q + 16'd1;
      end
    end
  end

  assign res_valid = (state_q == StFull);
  assign res_data  = data_q;
  assign res_id    = id_q;
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Directed bench for addsub_rr_arbiter: expected results queued at issue, checked by a monitor.
module tb_addsub_rr_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_sub;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_data;
  logic [1:0]   res_id;
  logic [15:0]  ops_done;
`ifdef ADDSUB_ARB_OVF_EN
  logic         res_ovf;
`endif

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  logic hold  = 1'b0;
  logic [3:0] fired;

  addsub_rr_arbiter #(.NUM_REQ(4), .WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
`ifdef ADDSUB_ARB_OVF_EN
    .res_ovf   (res_ovf),
`endif
    .ops_done  (ops_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // A result is consumed at the next rising edge whenever valid&ready holds mid-cycle.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got id %0d data %h expected none", res_id, res_data);
      end else begin
        mon_e = sb.pop_front();
        check("res_data", res_data, mon_e.data);
        check("res_id", 32'(res_id), 32'(mon_e.id));
`ifdef ADDSUB_ARB_OVF_EN
        check("res_ovf", 32'(res_ovf), 32'(mon_e.ovf));
`endif
      end
    end
  end

  task automatic to_neg();
    @(negedge clk);
  endtask

  // Finish the cycle: requesters drop a fired request unless told to keep it asserted.
  task automatic cyc_end();
    fired = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (!hold) req_valid = req_valid & ~fired;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      to_neg();
      cyc_end();
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic sub);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_sub[i]        = sub;
    req_valid[i]      = 1'b1;
  endtask

  task automatic push(input logic [1:0] id, input logic [31:0] data, input logic ovf);
    exp_t e;
    e.id   = id;
    e.data = data;
    e.ovf  = ovf;
    sb.push_back(e);
  endtask

  task automatic run_until_idle(input int n);
    for (int i = 0; i < n && req_valid != 4'b0; i++) begin
      to_neg();
      cyc_end();
    end
    check("fire_timeout", 32'(req_valid), 32'h0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    res_ready = 1'b1;

    // 1: reset state, then a single add with 1-cycle latency
    @(posedge clk);
    #1;
    set_req(0, 32'd1, 32'd1, 1'b0);
    to_neg();
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_res_id", 32'(res_id), 32'h0);
    check("rst_ops_done", 32'(ops_done), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    cyc_end();
    reset = 1'b0;
    push(2'd0, 32'd2, 1'b0);
    to_neg();
    check("t1_req_ready", 32'(req_ready), 32'h1);
    cyc_end();
    to_neg();
    check("t1_res_valid", 32'(res_valid), 32'h1);
    cyc_end();
    idle(2);

    // 2: all requesters continuously valid after a fresh reset
    reset = 1'b1;
    to_neg();
    cyc_end();
    reset = 1'b0;
    hold  = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 32'(100 * i), 32'(i + 1), 1'b0);
    push(2'd0, 32'd1, 1'b0);
    push(2'd1, 32'd102, 1'b0);
    push(2'd2, 32'd203, 1'b0);
    push(2'd3, 32'd304, 1'b0);
    push(2'd0, 32'd1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      to_neg();
      check("t2_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      check("t2_ops_done", 32'(ops_done), (k >= 2) ? 32'(k - 1) : 32'h0);
      cyc_end();
    end
    hold      = 1'b0;
    req_valid = '0;
    idle(1);
    to_neg();
    check("t2_ops_final", 32'(ops_done), 32'd5);
    cyc_end();

    // 3: two subtractions, pointer sits at 1
    set_req(2, 32'd2, 32'd2, 1'b1);
    set_req(1, 32'd0, 32'd1, 1'b1);
    push(2'd1, 32'hFFFF_FFFF, 1'b0);
    push(2'd2, 32'h0, 1'b0);
    to_neg();
    check("t3_first_grant", 32'(req_ready), 32'h2);
    cyc_end();
    run_until_idle(6);
    idle(2);

    // 4: backpressure holds the result and blocks grants
    res_ready = 1'b0;
    set_req(3, 32'd5, 32'd7, 1'b0);
    push(2'd3, 32'd12, 1'b0);
    to_neg();
    check("t4_grant3", 32'(req_ready), 32'h8);
    cyc_end();
    set_req(1, 32'd9, 32'd4, 1'b1);
    push(2'd1, 32'd5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      to_neg();
      check("t4_stall_ready", 32'(req_ready), 32'h0);
      check("t4_hold_valid", 32'(res_valid), 32'h1);
      check("t4_hold_data", res_data, 32'd12);
      check("t4_hold_id", 32'(res_id), 32'd3);
      cyc_end();
    end
    res_ready = 1'b1;
    to_neg();
    check("t4_drain_grant", 32'(req_ready), 32'h2);
    cyc_end();
    idle(3);
    to_neg();
    check("t4_ops_done", 32'(ops_done), 32'd9);
    cyc_end();

    // 5: reset while a result is pending and requests wait
    res_ready = 1'b0;
    set_req(2, 32'd1, 32'd1, 1'b0);
    to_neg();
    check("t5_grant2", 32'(req_ready), 32'h4);
    cyc_end();
    set_req(0, 32'd3, 32'd4, 1'b0);
    set_req(3, 32'd10, 32'd1, 1'b1);
    to_neg();
    check("t5_full_ready", 32'(req_ready), 32'h0);
    cyc_end();
    reset = 1'b1;
    to_neg();
    check("t5_rst_ready", 32'(req_ready), 32'h0);
    cyc_end();
    reset     = 1'b0;
    res_ready = 1'b1;
    push(2'd0, 32'd7, 1'b0);
    push(2'd3, 32'd9, 1'b0);
    to_neg();
    check("t5_res_valid", 32'(res_valid), 32'h0);
    check("t5_ops_done", 32'(ops_done), 32'h0);
    check("t5_res_data", res_data, 32'h0);
    check("t5_first_grant", 32'(req_ready), 32'h1);
    cyc_end();
    run_until_idle(6);
    idle(2);

    // 6: signed-overflow boundaries
    set_req(0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    set_req(1, 32'h8000_0000, 32'd1, 1'b1);
    set_req(2, 32'd5, 32'd3, 1'b1);
    push(2'd0, 32'h8000_0000, 1'b1);
    push(2'd1, 32'h7FFF_FFFF, 1'b1);
    push(2'd2, 32'd2, 1'b0);
    run_until_idle(8);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    idle(1);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
